spi_flash_sequencer: RTL and testbench
======================================

# spi_flash_sequencer

Command sequencer placed between the CPU-side register interface and the `spi_master_fl` serial engine. It turns one high-level flash request into the SPI transaction chain the flash needs:
- read: one transaction;
- status: one transaction;
- program and erase: write-enable, the operation, then status polling until the write-in-progress bit clears.

It owns the engine's request handshake exclusively, so software issues a single request and receives a single response.

## Interface
Parameters:
- POLL_MAX, 1024: maximum RDSR polls after program/erase before reporting timeout; 16-bit poll counter.
- POLL_GAP, 16: idle clk cycles between consecutive RDSR polls; 8-bit gap counter.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- req_op  in  2  request type: 0=READ, 1=PROGRAM, 2=ERASE (4 KB sector), 3=STATUS.
- req_addr  in  24  flash byte address.
- req_wdata  in  32  program data.
- rsp_valid  out  1  one-cycle pulse marking completion.
- rsp_rdata  out  32  READ: word read; STATUS: status byte in [7:0], zero-extended; else 0.
- rsp_err  out  1  poll timeout; valid with rsp_valid.
- busy  out  1  high when not IDLE.
- m_command  out  8  engine command byte.
- m_commtype  out  3  engine transaction type.
- m_address  out  32  engine address; upper 8 bits always 0.
- m_data_in  out  32  engine TX data.
- m_nmiso_bits  out  7  number of bits the engine receives.
- m_dummy_cycles  out  4  always 0.
- m_validflag  out  1  engine request level.
- m_tready  in  1  engine idle/ready.
- m_data_out  in  32  engine RX word; received bits are MSB-aligned.

## Operation
- Engine transaction encodings (command / commtype / nmiso_bits):
  - WREN: 0x06 / 000 / 0.
  - READ: 0x03 / 010 / 32.
  - PP: 0x02 / 100 / 0; data = req_wdata.
  - SE: 0x20 / 101 / 0.
  - RDSR: 0x05 / 001 / 8.
- On accept, latch req_op, req_addr and req_wdata; zero the poll counter.
- State machine:
  - IDLE → ISSUE(first txn) on accept. The first txn is WREN for PROGRAM/ERASE, otherwise the op itself.
  - ISSUE: drive the m_* fields and hold m_validflag=1 until m_tready=0 is sampled; then drop m_validflag and go to WAIT.
  - WAIT: hold until m_tready=1; then capture m_data_out.
  - After WREN done → ISSUE(PP or SE).
  - After PP/SE done → GAP.
  - GAP: count POLL_GAP cycles → ISSUE(RDSR), incrementing the poll counter.
  - After a poll RDSR done:
    - m_data_out[24]=0 (WIP clear) → RESP, rsp_err=0;
    - else if poll count = POLL_MAX → RESP, rsp_err=1;
    - else → GAP.
  - After READ done → RESP, rsp_rdata = m_data_out.
  - After STATUS done → RESP, rsp_rdata = {24'b0, m_data_out[31:24]}.
  - RESP: rsp_valid=1 for one cycle → IDLE.
- m_* fields are constant for the whole of ISSUE and WAIT.
- A req_valid arriving while busy is ignored (req_ready=0); it is not queued.

## Timing
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, m_validflag=0, and all m_* fields 0. State → IDLE, counters → 0.
- Reset asserted mid-transaction: m_validflag drops on the next edge. The engine finishes its serial frame on its own; after reset the sequencer waits in IDLE and does not issue until the next accept.
- Accept edge → m_validflag=1 on the next cycle (1-cycle issue latency).
- m_validflag is never reasserted in the same cycle m_tready is sampled low, so there is always at least one low cycle between requests. This lets the engine re-arm its edge detector.
- Last WAIT cycle (m_tready=1) → RESP next cycle → rsp_validflag... specifically: rsp_valid=1 in RESP, and req_ready=1 on the cycle after rsp_valid.
- Poll count is compared before increment; exactly POLL_MAX RDSRs are issued on timeout.
- Counters saturate at their widths; POLL_GAP=0 means the next RDSR is issued immediately.

## Structure
- Shared package `spi_fl_pkg`:
  - op codes;
  - flash command bytes (0x06, 0x03, 0x02, 0x20, 0x05);
  - commtype encodings (000, 001, 010, 100, 101);
  - the state enumeration.
- One sub-module, `spi_fl_txn`, implements the ISSUE/WAIT handshake:
  - inputs: start, the field set;
  - outputs: done pulse, captured RX word.
- The top-level FSM only selects fields and sequences transactions.

## Test plan
- READ 0x001000, engine model returns 0xDEADBEEF → exactly one transaction (0x03/010/32); rsp_rdata=0xDEADBEEF, rsp_err=0.
- PROGRAM 0x000040 with data 0x12345678, WIP high for 3 polls → sequence WREN, PP (addr 0x40, data 0x12345678), then 4 RDSRs; one rsp_valid with rsp_err=0.
- ERASE with WIP stuck at 1, POLL_MAX=4 → exactly 4 RDSRs after SE; rsp_err=1.
- STATUS with engine returning 0xA5000000 → rsp_rdata=0x000000A5.
- Second req_valid during PROGRAM is not accepted; the handshake shows m_validflag low for ≥1 cycle between transactions.
- rst asserted during PP WAIT → next cycle m_validflag=0, busy=0, rsp_valid=0; a subsequent READ completes normally.

Source files
------------

// File: rtl/spi_fl_pkg.sv
// spi_fl_pkg: op codes, flash command bytes, engine commtypes, state enums and field lookup for the flash sequencer
package spi_fl_pkg;
    typedef enum logic [1:0] {OP_READ = 2'd0, OP_PROGRAM = 2'd1, OP_ERASE = 2'd2, OP_STATUS = 2'd3} op_e;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'h20;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [2:0] CT_WREN  = 3'b000;
    localparam logic [2:0] CT_RDSR  = 3'b001;
    localparam logic [2:0] CT_READ  = 3'b010;
    localparam logic [2:0] CT_PP    = 3'b100;
    localparam logic [2:0] CT_SE    = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_TXN, S_GAP, S_RESP} state_e;
    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WAIT} txn_state_e;
    typedef enum logic [2:0] {K_WREN, K_READ, K_PP, K_SE, K_RDSR} kind_e;
    typedef struct packed {
        logic [7:0] command;
        logic [2:0] commtype;
        logic [6:0] nmiso_bits;
    } txn_fmt_t;
    function automatic txn_fmt_t fmt_of(kind_e k);
        return k == K_WREN ? '{CMD_WREN, CT_WREN, 7'd0}
             : k == K_READ ? '{CMD_READ, CT_READ, 7'd32}
             : k == K_PP   ? '{CMD_PP,   CT_PP,   7'd0}
             : k == K_SE   ? '{CMD_SE,   CT_SE,   7'd0}
             :               '{CMD_RDSR, CT_RDSR, 7'd8};
    endfunction
endpackage

// File: rtl/spi_fl_txn.sv
// spi_fl_txn: one engine transaction -- latch fields on start, hold m_validflag until the engine goes busy, then wait for it to finish
// ports: clk/rst; start + command/commtype/address/data_in/nmiso_bits field set; done pulse and rx_data (valid with done);
//        m_* engine request fields, m_tready/m_data_out from the engine
module spi_fl_txn
    import spi_fl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  command,
    input  logic [2:0]  commtype,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [6:0]  nmiso_bits,
    output logic        done,
    output logic [31:0] rx_data,
    output logic [7:0]  m_command,
    output logic [2:0]  m_commtype,
    output logic [31:0] m_address,
    output logic [31:0] m_data_in,
    output logic [6:0]  m_nmiso_bits,
    output logic [3:0]  m_dummy_cycles,
    output logic        m_validflag,
    input  logic        m_tready,
    input  logic [31:0] m_data_out
);
    txn_state_e state, state_nxt;
    logic load;
    assign done = state == T_WAIT && m_tready;
    assign rx_data = m_data_out;
    assign m_dummy_cycles = '0;
    // a new transaction may be chained on the very cycle the previous one completes;
    // m_validflag has been low throughout WAIT, so the engine still sees a fresh rising edge
    assign load = start && (state == T_IDLE || done);
    always_comb begin
        state_nxt = state;
        state_nxt = load ? T_ISSUE
                  : state == T_ISSUE && !m_tready ? T_WAIT
                  : done ? T_IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= T_IDLE;
            m_validflag  <= 1'b0;
            m_command    <= '0;
            m_commtype   <= '0;
            m_address    <= '0;
            m_data_in    <= '0;
            m_nmiso_bits <= '0;
        end else begin
            state       <= state_nxt;
            m_validflag <= state_nxt == T_ISSUE;
            if (load) begin
                m_command    <= command;
                m_commtype   <= commtype;
                m_address    <= address;
                m_data_in    <= data_in;
                m_nmiso_bits <= nmiso_bits;
            end
        end
    end
endmodule

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: turns one flash request into the WREN / op / RDSR-poll chain on the spi_master_fl engine
// ports: clk/rst; req_valid/req_ready/req_op/req_addr/req_wdata request side; rsp_valid/rsp_rdata/rsp_err response;
//        busy; m_* engine request fields with m_tready/m_data_out engine status
module spi_flash_sequencer
    import spi_fl_pkg::*;
#(
    parameter int unsigned POLL_MAX = 1024,
    parameter int unsigned POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  m_command,
    output logic [2:0]  m_commtype,
    output logic [31:0] m_address,
    output logic [31:0] m_data_in,
    output logic [6:0]  m_nmiso_bits,
    output logic [3:0]  m_dummy_cycles,
    output logic        m_validflag,
    input  logic        m_tready,
    input  logic [31:0] m_data_out
);
    state_e state, state_nxt;
    kind_e kind, kind_nxt, kind_first;
    op_e op_q;
    logic [23:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] poll_cnt;
    logic [7:0] gap_cnt;
    logic accept, start, done, polling, wip;
    logic [31:0] rx_data;
    txn_fmt_t fmt;
    assign req_ready = state == S_IDLE;
    assign busy = state != S_IDLE;
    assign rsp_valid = state == S_RESP;
    assign accept = req_valid && req_ready;
    assign kind_first = op_e'(req_op) == OP_READ ? K_READ : op_e'(req_op) == OP_STATUS ? K_RDSR : K_WREN;
    assign polling = kind == K_RDSR && op_q != OP_STATUS;
    assign wip = rx_data[24];
    assign fmt = fmt_of(kind_nxt);
    always_comb begin
        state_nxt = state;
        kind_nxt = kind;
        start = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                start = 1'b1;
                kind_nxt = kind_first;
                state_nxt = S_TXN;
            end
            S_TXN: if (done) begin
                if (kind == K_WREN) begin
                    start = 1'b1;
                    kind_nxt = op_q == OP_PROGRAM ? K_PP : K_SE;
                end else begin
                    state_nxt = kind == K_PP || kind == K_SE ? S_GAP
                              : polling && wip && poll_cnt != 16'(POLL_MAX) ? S_GAP : S_RESP;
                end
            end
            S_GAP: if (gap_cnt >= 8'(POLL_GAP)) begin
                start = 1'b1;
                kind_nxt = K_RDSR;
                state_nxt = S_TXN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            kind      <= K_WREN;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            kind  <= kind_nxt;
            if (accept) begin
                op_q      <= op_e'(req_op);
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                poll_cnt  <= '0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
            if (state == S_GAP && start && poll_cnt != 16'hFFFF)
                poll_cnt <= poll_cnt + 16'd1;
            if (state != S_GAP)
                gap_cnt <= '0;
            else if (gap_cnt != 8'hFF)
                gap_cnt <= gap_cnt + 8'd1;
            if (state == S_TXN && state_nxt == S_RESP) begin
                rsp_rdata <= kind == K_READ ? rx_data : kind == K_RDSR && op_q == OP_STATUS ? {24'b0, rx_data[31:24]} : '0;
                rsp_err   <= polling && wip;
            end
        end
    end
    spi_fl_txn u_txn (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .command        (fmt.command),
        .commtype       (fmt.commtype),
        .address        (kind_nxt == K_READ || kind_nxt == K_PP || kind_nxt == K_SE ? {8'h00, accept ? req_addr : addr_q} : 32'h0),
        .data_in        (kind_nxt == K_PP ? wdata_q : 32'h0),
        .nmiso_bits     (fmt.nmiso_bits),
        .done           (done),
        .rx_data        (rx_data),
        .m_command      (m_command),
        .m_commtype     (m_commtype),
        .m_address      (m_address),
        .m_data_in      (m_data_in),
        .m_nmiso_bits   (m_nmiso_bits),
        .m_dummy_cycles (m_dummy_cycles),
        .m_validflag    (m_validflag),
        .m_tready       (m_tready),
        .m_data_out     (m_data_out)
    );
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// tb_spi_flash_sequencer: directed checks of the flash sequencer against a simple behavioural SPI engine
module tb_spi_flash_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  m_command;
    logic [2:0]  m_commtype;
    logic [31:0] m_address;
    logic [31:0] m_data_in;
    logic [6:0]  m_nmiso_bits;
    logic [3:0]  m_dummy_cycles;
    logic        m_validflag;
    logic        m_tready = 1'b1;
    logic [31:0] m_data_out = '0;

    int n_tests = 0;
    int n_fail = 0;

    spi_flash_sequencer #(.POLL_MAX(4), .POLL_GAP(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .m_command      (m_command),
        .m_commtype     (m_commtype),
        .m_address      (m_address),
        .m_data_in      (m_data_in),
        .m_nmiso_bits   (m_nmiso_bits),
        .m_dummy_cycles (m_dummy_cycles),
        .m_validflag    (m_validflag),
        .m_tready       (m_tready),
        .m_data_out     (m_data_out)
    );

    always #5 clk = ~clk;

    // engine model: starts a 4-cycle frame on a rising m_validflag while idle
    logic [7:0]  lg_cmd [64];
    logic [2:0]  lg_type[64];
    logic [31:0] lg_addr[64];
    logic [31:0] lg_data[64];
    logic [6:0]  lg_miso[64];
    int          lg_low [64];
    int          log_n = 0;
    int          eng_cnt = 0;
    int          low_run = 0;
    int          wip_left = 0;
    logic [31:0] rd_word = '0;
    logic [31:0] status_word = '0;
    logic [31:0] eng_rx = '0;
    logic        vf_prev = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) begin
        vf_prev <= m_validflag;
        low_run <= m_validflag ? 0 : low_run + 1;
        if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                m_tready <= 1'b1;
                m_data_out <= eng_rx;
            end
        end else if (m_validflag && !vf_prev && m_tready) begin
            if (log_n < 64) begin
                lg_cmd[log_n]  <= m_command;
                lg_type[log_n] <= m_commtype;
                lg_addr[log_n] <= m_address;
                lg_data[log_n] <= m_data_in;
                lg_miso[log_n] <= m_nmiso_bits;
                lg_low[log_n]  <= low_run;
            end
            log_n <= log_n + 1;
            m_tready <= 1'b0;
            eng_cnt <= 4;
            if (m_command == 8'h03)
                eng_rx <= rd_word;
            else if (m_command == 8'h05) begin
                eng_rx <= wip_left > 0 ? 32'h0100_0000 : status_word;
                if (wip_left > 0) wip_left <= wip_left - 1;
            end else
                eng_rx <= 32'h0;
        end
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            last_rdata <= rsp_rdata;
            last_err <= rsp_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_addr = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n0);
        int k;
        k = 0;
        while (rsp_cnt == n0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rsp_timeout"}, 32'(k < 3000), 32'd1);
    endtask

    task automatic check_txn(input string tag, input int i, input logic [7:0] cmd, input logic [2:0] ct,
                             input logic [31:0] addr, input logic [31:0] data, input logic [6:0] miso);
        check({tag, "_cmd"},  32'(lg_cmd[i]),  32'(cmd));
        check({tag, "_type"}, 32'(lg_type[i]), 32'(ct));
        check({tag, "_addr"}, lg_addr[i], addr);
        check({tag, "_data"}, lg_data[i], data);
        check({tag, "_miso"}, 32'(lg_miso[i]), 32'(miso));
    endtask

    initial begin
        int b, r, k;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_validflag", 32'(m_validflag), 32'd0);
        check("rst_fields", {m_command, 5'd0, m_commtype, 1'b0, m_nmiso_bits, 4'd0, m_dummy_cycles}, 32'd0);
        check("rst_addr_data", m_address | m_data_in, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // READ
        rd_word = 32'hDEAD_BEEF;
        b = log_n; r = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_addr = 24'h001000;
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_issue_latency", 32'(m_validflag), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        wait_rsp("rd", r);
        @(negedge clk);
        check("rd_ntxn", 32'(log_n - b), 32'd1);
        check_txn("rd_t0", b, 8'h03, 3'b010, 32'h0000_1000, 32'h0, 7'd32);
        check("rd_rdata", last_rdata, 32'hDEAD_BEEF);
        check("rd_err", 32'(last_err), 32'd0);
        check("rd_dummy", 32'(m_dummy_cycles), 32'd0);
        check("rd_ready_after", 32'(req_ready), 32'd1);

        // PROGRAM, WIP high for 3 polls; a second request during it must be ignored
        wip_left = 3; status_word = 32'h0;
        b = log_n; r = rsp_cnt;
        issue(2'd1, 24'h000040, 32'h1234_5678);
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_addr = 24'h000100;
        @(negedge clk);
        check("pp_second_req_ready", 32'(req_ready), 32'd0);
        repeat (5) @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("pp", r);
        repeat (20) @(negedge clk);
        check("pp_ntxn", 32'(log_n - b), 32'd6);
        check("pp_nrsp", 32'(rsp_cnt - r), 32'd1);
        check_txn("pp_wren", b, 8'h06, 3'b000, 32'h0, 32'h0, 7'd0);
        check_txn("pp_pp", b + 1, 8'h02, 3'b100, 32'h0000_0040, 32'h1234_5678, 7'd0);
        for (int i = 2; i < 6; i++) begin
            check($sformatf("pp_rdsr%0d_cmd", i - 2), 32'(lg_cmd[b + i]), 32'h05);
            check($sformatf("pp_rdsr%0d_type", i - 2), 32'(lg_type[b + i]), 32'd1);
            check($sformatf("pp_rdsr%0d_miso", i - 2), 32'(lg_miso[b + i]), 32'd8);
        end
        check("pp_vf_low_gap", 32'(lg_low[b + 1] >= 1), 32'd1);
        check("pp_err", 32'(last_err), 32'd0);
        check("pp_rdata", last_rdata, 32'd0);

        // ERASE, WIP stuck -> timeout after exactly POLL_MAX polls
        wip_left = 1000;
        b = log_n; r = rsp_cnt;
        issue(2'd2, 24'h003000, 32'h0);
        wait_rsp("se", r);
        repeat (20) @(negedge clk);
        check("se_ntxn", 32'(log_n - b), 32'd6);
        check_txn("se_wren", b, 8'h06, 3'b000, 32'h0, 32'h0, 7'd0);
        check_txn("se_se", b + 1, 8'h20, 3'b101, 32'h0000_3000, 32'h0, 7'd0);
        check("se_last_cmd", 32'(lg_cmd[b + 5]), 32'h05);
        check("se_err", 32'(last_err), 32'd1);
        wip_left = 0;

        // STATUS
        status_word = 32'hA500_0000;
        b = log_n; r = rsp_cnt;
        issue(2'd3, 24'h0, 32'h0);
        wait_rsp("st", r);
        @(negedge clk);
        check("st_ntxn", 32'(log_n - b), 32'd1);
        check_txn("st_t0", b, 8'h05, 3'b001, 32'h0, 32'h0, 7'd8);
        check("st_rdata", last_rdata, 32'h0000_00A5);
        check("st_err", 32'(last_err), 32'd0);

        // reset while the PP transaction is outstanding
        wip_left = 0; status_word = 32'h0;
        b = log_n; r = rsp_cnt;
        issue(2'd1, 24'h000080, 32'hCAFE_F00D);
        k = 0;
        while (log_n - b < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reach_pp", 32'(k < 200), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_validflag", 32'(m_validflag), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstmid_no_reissue", 32'(log_n - b), 32'd2);
        check("rstmid_no_rsp", 32'(rsp_cnt - r), 32'd0);
        rd_word = 32'h0BAD_F00D;
        b = log_n; r = rsp_cnt;
        issue(2'd0, 24'h00ABCD, 32'h0);
        wait_rsp("rstmid_rd", r);
        @(negedge clk);
        check("rstmid_rd_ntxn", 32'(log_n - b), 32'd1);
        check("rstmid_rd_addr", lg_addr[b], 32'h0000_ABCD);
        check("rstmid_rd_rdata", last_rdata, 32'h0BAD_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
